// File: rtl/snake_key_if.sv
// Avalon-MM slave bus bundle for the snake_key push-button port.
// The master modport is the Nios II side; the slave modport is the key port.
interface snake_key_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        irq;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata, irq
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata, irq
  );
endinterface

// File: rtl/snake_key.sv
// Push-button input port: synchronises and debounces each key, latches debounced
// edges into a write-1-to-clear capture register and raises a masked level irq.
module snake_key #(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter bit IDLE_LEVEL      = 1'b1,
  parameter int EDGE_TYPE       = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_port,
  snake_key_if.slave       bus
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [WIDTH-1:0] IDLE = {WIDTH{IDLE_LEVEL}};
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] sync1, sync2, db, db_next;
  logic [WIDTH-1:0] irqmask, edgecapture;
  logic [WIDTH-1:0] rise, fall, edge_hit, clear_bits;
  logic [CW-1:0]    cnt [WIDTH];
  logic [CW-1:0]    cnt_next [WIDTH];
  logic             wr;
  logic             unused_writedata;

  assign wr = bus.chipselect && !bus.write_n;
  assign unused_writedata = &{1'b0, bus.writedata};

  // Each key counts consecutive cycles of disagreement; agreement restarts the count.
  always_comb begin
    for (int i = 0; i < WIDTH; i++) begin
      db_next[i]  = db[i];
      cnt_next[i] = '0;
      if (sync2[i] != db[i]) begin
        if (cnt[i] == CNT_LAST) begin
          db_next[i] = sync2[i];
        end else begin
          cnt_next[i] = cnt[i] + CW'(1);
        end
      end
    end
  end

  assign rise = db_next & ~db;
  assign fall = ~db_next & db;

  generate
    if (EDGE_TYPE == 0) begin : g_rise
      assign edge_hit = rise;
    end else if (EDGE_TYPE == 1) begin : g_fall
      assign edge_hit = fall;
    end else begin : g_any
      assign edge_hit = rise | fall;
    end
  endgenerate

  assign clear_bits = (wr && bus.address == 2'd3) ? bus.writedata[WIDTH-1:0] : '0;

  // Capture set is OR'ed in after the clear so a same-edge set survives.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1       <= IDLE;
      sync2       <= IDLE;
      db          <= IDLE;
      irqmask     <= '0;
      edgecapture <= '0;
      for (int i = 0; i < WIDTH; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      sync1       <= in_port;
      sync2       <= sync1;
      db          <= db_next;
      edgecapture <= (edgecapture & ~clear_bits) | edge_hit;
      for (int i = 0; i < WIDTH; i++) begin
        cnt[i] <= cnt_next[i];
      end
      if (wr && bus.address == 2'd2) begin
        irqmask <= bus.writedata[WIDTH-1:0];
      end
    end
  end

  always_comb begin
    bus.readdata = '0;
    case (bus.address)
      2'd0:    bus.readdata = 32'(db);
      2'd2:    bus.readdata = 32'(irqmask);
      2'd3:    bus.readdata = 32'(edgecapture);
      default: bus.readdata = '0;
    endcase
  end

  assign bus.irq = |(edgecapture & irqmask);
endmodule
